// File: rtl/act_pkg.sv
// Shared definitions for the activation stage: mode encodings and the
// signed saturation helper used by every lane.
package act_pkg;

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_RELU   = 2'd1;
   localparam logic [1:0] MODE_LEAKY  = 2'd2;
   localparam logic [1:0] MODE_CLIP   = 2'd3;

   // Clamp a sign-extended value to the signed range of to_bw bits.
   function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                              input int from_bw,
                                              input int to_bw);
      logic signed [63:0] hi_s;
      logic signed [63:0] lo_s;
      hi_s = (64'sd1 <<< (to_bw - 1)) - 64'sd1;
      lo_s = -(64'sd1 <<< (to_bw - 1));
      if (to_bw >= from_bw) begin
         sat = x;
      end else if (x > hi_s) begin
         sat = hi_s;
      end else if (x < lo_s) begin
         sat = lo_s;
      end else begin
         sat = x;
      end
   endfunction

endpackage

// File: rtl/relu_lane.sv
// One activation lane: stage-1 mode logic with negative flag, and the
// stage-2 saturation of the registered stage-1 result.
module relu_lane
   import act_pkg::*;
#(
   parameter int BO_BW      = 16,
   parameter int ACT_BW     = 8,
   parameter int LEAK_SHIFT = 3
) (
   input  logic signed [BO_BW-1:0]  x,
   input  logic        [1:0]        mode,
   input  logic        [BO_BW-1:0]  clip,
   output logic signed [BO_BW-1:0]  y,
   output logic                     neg,
   input  logic signed [BO_BW-1:0]  y_reg,
   output logic signed [ACT_BW-1:0] act
);

   logic is_neg_s;

   // Stage-1 activation selected per beat by mode.
   always_comb begin
      is_neg_s = x[BO_BW-1];
      y        = x;
      neg      = 1'b0;
      case (mode)
         MODE_BYPASS: y = x;
         MODE_RELU: begin
            if (is_neg_s) begin
               y   = {BO_BW{1'b0}};
               neg = 1'b1;
            end else begin
               y = x;
            end
         end
         MODE_LEAKY: begin
            if (is_neg_s) begin
               y = x >>> LEAK_SHIFT;
            end else begin
               y = x;
            end
         end
         MODE_CLIP: begin
            // Clip ceiling is unsigned, so compare with a zero-extended x.
            if (is_neg_s) begin
               y   = {BO_BW{1'b0}};
               neg = 1'b1;
            end else if ({1'b0, x} > {1'b0, clip}) begin
               y = clip;
            end else begin
               y = x;
            end
         end
         default: y = x;
      endcase
   end

   // Stage-2 saturation to the output element width.
   always_comb begin
      act = ACT_BW'(sat({{(64-BO_BW){y_reg[BO_BW-1]}}, y_reg}, BO_BW, ACT_BW));
   end

endmodule

// File: rtl/relu_bound_pipe.sv
// Multi-lane activation stage with a 2-deep valid/ready pipeline and a
// saturating count of lanes zeroed by negative inputs.
module relu_bound_pipe
   import act_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int BO_BW      = 16,
   parameter int ACT_BW     = 8,
   parameter int LEAK_SHIFT = 3,
   parameter int CNT_BW     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [LANES*BO_BW-1:0]    i_data,
   input  logic                      i_last,
   input  logic [1:0]                i_mode,
   input  logic [BO_BW-1:0]          i_clip,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [LANES*ACT_BW-1:0]   o_data,
   output logic                      o_last,
   input  logic                      i_cnt_clr,
   output logic [CNT_BW-1:0]         o_zero_cnt
);

   localparam int NW = $clog2(LANES + 1);
   localparam int SW = CNT_BW + NW;
   localparam logic [SW-1:0] CNT_MAX = SW'({CNT_BW{1'b1}});

   logic [LANES*BO_BW-1:0]  y_s;
   logic [LANES-1:0]        neg_s;
   logic [LANES*ACT_BW-1:0] act_s;
   logic [NW-1:0]           neg_cnt_s;
   logic [SW-1:0]           sum_s;
   logic [CNT_BW-1:0]       cnt_inc_s;
   logic                    s2_adv_s;
   logic                    s1_adv_s;
   logic                    xfer_s;

   logic                    s1_valid_r;
   logic [LANES*BO_BW-1:0]  s1_y_r;
   logic [LANES-1:0]        s1_neg_r;
   logic                    s1_last_r;
   logic                    o_valid_r;
   logic [LANES*ACT_BW-1:0] o_data_r;
   logic                    o_last_r;
   logic [NW-1:0]           o_negcnt_r;
   logic [CNT_BW-1:0]       cnt_r;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      relu_lane #(
         .BO_BW      (BO_BW),
         .ACT_BW     (ACT_BW),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
         .x     (i_data[g*BO_BW +: BO_BW]),
         .mode  (i_mode),
         .clip  (i_clip),
         .y     (y_s[g*BO_BW +: BO_BW]),
         .neg   (neg_s[g]),
         .y_reg (s1_y_r[g*BO_BW +: BO_BW]),
         .act   (act_s[g*ACT_BW +: ACT_BW])
      );
   end

   assign s2_adv_s = !o_valid_r || i_ready;
   assign s1_adv_s = !s1_valid_r || s2_adv_s;
   assign xfer_s   = o_valid_r && i_ready;
   assign o_ready  = s1_adv_s;

   // Lane popcount of stage-1 negative flags and saturating counter increment.
   always_comb begin
      neg_cnt_s = {NW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         neg_cnt_s = neg_cnt_s + NW'(s1_neg_r[i]);
      end
      sum_s = SW'(cnt_r) + SW'(o_negcnt_r);
      if (sum_s > CNT_MAX) begin
         cnt_inc_s = {CNT_BW{1'b1}};
      end else begin
         cnt_inc_s = sum_s[CNT_BW-1:0];
      end
   end

   // Pipeline stages and zeroed-element counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_y_r     <= {(LANES*BO_BW){1'b0}};
         s1_neg_r   <= {LANES{1'b0}};
         s1_last_r  <= 1'b0;
         o_valid_r  <= 1'b0;
         o_data_r   <= {(LANES*ACT_BW){1'b0}};
         o_last_r   <= 1'b0;
         o_negcnt_r <= {NW{1'b0}};
         cnt_r      <= {CNT_BW{1'b0}};
      end else begin
         if (s1_adv_s) begin
            s1_valid_r <= i_valid;
            if (i_valid) begin
               s1_y_r    <= y_s;
               s1_neg_r  <= neg_s;
               s1_last_r <= i_last;
            end
         end
         // Payload only moves with a valid beat, so a stalled output holds.
         if (s2_adv_s) begin
            o_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               o_data_r   <= act_s;
               o_last_r   <= s1_last_r;
               o_negcnt_r <= neg_cnt_s;
            end
         end
         if (i_cnt_clr) begin
            cnt_r <= {CNT_BW{1'b0}};
         end else if (xfer_s) begin
            cnt_r <= cnt_inc_s;
         end
      end
   end

   assign o_valid    = o_valid_r;
   assign o_data     = o_data_r;
   assign o_last     = o_last_r;
   assign o_zero_cnt = cnt_r;

endmodule

// File: tb/tb_relu_bound_pipe.sv
// Self-checking bench for relu_bound_pipe: table vectors, backpressure,
// counter saturation/clear and mid-stream reset, scored through a queue.
module tb_relu_bound_pipe;

   localparam int LANES = 4;
   localparam int BO_BW = 16;
   localparam int ACT_BW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    reset, i_valid, i_last, i_ready, i_cnt_clr;
   logic [1:0]              i_mode;
   logic [BO_BW-1:0]        i_clip;
   logic [LANES*BO_BW-1:0]  i_data;
   logic                    o_ready, o_valid, o_last;
   logic [LANES*ACT_BW-1:0] o_data;
   logic [15:0]             o_zero_cnt;
   logic                    o_ready4, o_valid4, o_last4;
   logic [LANES*ACT_BW-1:0] o_data4;
   logic [3:0]              o_zero_cnt4;

   relu_bound_pipe #(.LANES(4), .BO_BW(16), .ACT_BW(8), .LEAK_SHIFT(3), .CNT_BW(16)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
      .i_last(i_last), .i_mode(i_mode), .i_clip(i_clip), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_last(o_last), .i_cnt_clr(i_cnt_clr), .o_zero_cnt(o_zero_cnt));

   relu_bound_pipe #(.LANES(4), .BO_BW(16), .ACT_BW(8), .LEAK_SHIFT(3), .CNT_BW(4)) dut4 (
      .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready4), .i_data(i_data),
      .i_last(i_last), .i_mode(i_mode), .i_clip(i_clip), .o_valid(o_valid4), .i_ready(i_ready),
      .o_data(o_data4), .o_last(o_last4), .i_cnt_clr(i_cnt_clr), .o_zero_cnt(o_zero_cnt4));

   typedef struct {
      logic [LANES*ACT_BW-1:0] data;
      logic                    last;
      int                      negs;
      int                      acc_cyc;
      bit                      lat_chk;
   } exp_t;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] clip;
      int          in_v [4];
      int          ex_v [4];
      int          negs;
   } vec_t;

   exp_t q[$];
   exp_t pend;
   vec_t tv[8];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int cnt_exp = 0;
   int cnt4_exp = 0;
   int out_cnt = 0;
   bit prev_stall = 1'b0;
   bit ready_low_seen = 1'b0;
   logic [LANES*ACT_BW-1:0] prev_data;
   logic prev_last;
   bit acc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference activation for one beat, independent of the RTL structure.
   task automatic model_beat(input logic [63:0] data, input logic [1:0] mode, input logic [15:0] clip,
                             output logic [31:0] res, output int negs);
      negs = 0;
      res = 32'd0;
      for (int l = 0; l < LANES; l++) begin
         int x;
         int y;
         x = $signed(data[l*16 +: 16]);
         case (mode)
            2'd0: y = x;
            2'd1: y = (x < 0) ? 0 : x;
            2'd2: y = (x < 0) ? (x >>> 3) : x;
            default: y = (x < 0) ? 0 : ((x > int'(clip)) ? int'(clip) : x);
         endcase
         if (y > 127) y = 127;
         if (y < -128) y = -128;
         res[l*8 +: 8] = y[7:0];
         if (x < 0 && (mode == 2'd1 || mode == 2'd3)) negs++;
      end
   endtask

   function automatic logic [63:0] pack16(input int a, input int b, input int c, input int d);
      logic [63:0] r;
      r = {d[15:0], c[15:0], b[15:0], a[15:0]};
      return r;
   endfunction

   function automatic logic [31:0] pack8(input int a, input int b, input int c, input int d);
      logic [31:0] r;
      r = {d[7:0], c[7:0], b[7:0], a[7:0]};
      return r;
   endfunction

   task automatic set_vec(input int idx, input logic [1:0] m, input logic [15:0] c,
                          input int a0, input int a1, input int a2, input int a3,
                          input int e0, input int e1, input int e2, input int e3, input int n);
      tv[idx].mode = m;
      tv[idx].clip = c;
      tv[idx].in_v = '{a0, a1, a2, a3};
      tv[idx].ex_v = '{e0, e1, e2, e3};
      tv[idx].negs = n;
   endtask

   // One clock: score outputs, record accepted beats, then advance to the next negedge.
   task automatic cycle(output bit accepted);
      exp_t e;
      #1;
      accepted = 1'b0;
      if (reset) begin
         q.delete();
         cnt_exp = 0;
         cnt4_exp = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_data", o_data, prev_data);
            chk("hold_last", o_last, prev_last);
         end
         if (o_valid && i_ready) begin
            out_cnt++;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got data %0h expected none", o_data);
            end else begin
               e = q.pop_front();
               chk("data", o_data, e.data);
               chk("last", o_last, e.last);
               if (e.lat_chk) chk("latency", cyc - e.acc_cyc, 2);
               cnt_exp = (cnt_exp + e.negs > 65535) ? 65535 : cnt_exp + e.negs;
               cnt4_exp = (cnt4_exp + e.negs > 15) ? 15 : cnt4_exp + e.negs;
            end
         end
         if (i_cnt_clr) begin
            cnt_exp = 0;
            cnt4_exp = 0;
         end
         if (i_valid && !o_ready) ready_low_seen = 1'b1;
         prev_stall = o_valid && !i_ready;
         prev_data = o_data;
         prev_last = o_last;
         if (i_valid && o_ready) begin
            accepted = 1'b1;
            pend.acc_cyc = cyc;
            q.push_back(pend);
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      bit a;
      i_valid = 1'b0;
      for (int k = 0; k < 30 && q.size() > 0; k++) cycle(a);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
         q.delete();
      end
   endtask

   // Drive one ReLU-style beat using the reference model for expectations.
   task automatic send_model(input logic [63:0] d, input logic [1:0] m, input logic [15:0] c,
                             input logic lst, input bit lat);
      logic [31:0] r;
      int n;
      model_beat(d, m, c, r, n);
      i_valid = 1'b1;
      i_data = d;
      i_mode = m;
      i_clip = c;
      i_last = lst;
      pend.data = r;
      pend.last = lst;
      pend.negs = n;
      pend.lat_chk = lat;
   endtask

   initial begin
      logic [63:0] bd[6];
      logic [1:0]  bm[6];
      logic [15:0] bc[6];
      int idx;
      int out_start;

      set_vec(0, 2'd1, 16'd0, -5, 0, 100, 300, 0, 0, 100, 127, 1);
      set_vec(1, 2'd2, 16'd0, -80, -3, 1000, -2000, -10, -1, 127, -128, 0);
      set_vec(2, 2'd3, 16'd6, -1, 3, 6, 50, 0, 3, 6, 6, 1);
      set_vec(3, 2'd0, 16'd6, -1, 3, 6, 50, -1, 3, 6, 50, 0);
      set_vec(4, 2'd3, 16'hFFFF, 32767, -32768, 7, -7, 127, 0, 7, 0, 2);
      set_vec(5, 2'd2, 16'd0, -32768, -1, -8, -9, -128, -1, -1, -2, 0);
      set_vec(6, 2'd0, 16'd0, -129, -128, 127, 128, -128, -128, 127, 127, 0);
      set_vec(7, 2'd1, 16'd0, 0, -1, 1, -32768, 0, 0, 1, 0, 2);

      reset = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
      i_mode = 2'd0; i_clip = 16'd0; i_data = 64'd0;
      pend = '{data: 32'd0, last: 1'b0, negs: 0, acc_cyc: 0, lat_chk: 1'b0};
      @(negedge clk);
      cycle(acc);
      cycle(acc);
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_o_data", o_data, 32'd0);
      chk("rst_o_last", o_last, 1'b0);
      chk("rst_cnt", o_zero_cnt, 16'd0);
      chk("rst_o_ready", o_ready, 1'b1);
      reset = 1'b0;

      // Table vectors, one isolated beat each.
      for (int i = 0; i < 8; i++) begin
         i_valid = 1'b1;
         i_data = pack16(tv[i].in_v[0], tv[i].in_v[1], tv[i].in_v[2], tv[i].in_v[3]);
         i_mode = tv[i].mode;
         i_clip = tv[i].clip;
         i_last = (i == 7);
         pend.data = pack8(tv[i].ex_v[0], tv[i].ex_v[1], tv[i].ex_v[2], tv[i].ex_v[3]);
         pend.last = (i == 7);
         pend.negs = tv[i].negs;
         pend.lat_chk = 1'b1;
         cycle(acc);
         chk("tv_accept", acc, 1'b1);
         drain();
         chk("tv_cnt", o_zero_cnt, cnt_exp);
      end

      // Backpressure: 6 back-to-back beats, i_ready low for cycles 3..7.
      for (int b = 0; b < 6; b++) begin
         bd[b] = {$urandom, $urandom};
         bm[b] = 2'($urandom_range(0, 3));
         bc[b] = 16'($urandom_range(0, 200));
      end
      idx = 0;
      out_start = out_cnt;
      ready_low_seen = 1'b0;
      for (int k = 0; k < 40 && (idx < 6 || q.size() > 0); k++) begin
         i_ready = !(k >= 3 && k < 8);
         if (idx < 6) send_model(bd[idx], bm[idx], bc[idx], (idx == 5), 1'b0);
         else i_valid = 1'b0;
         cycle(acc);
         if (acc) idx++;
      end
      i_ready = 1'b1;
      chk("bp_ready_dropped", ready_low_seen, 1'b1);
      chk("bp_beats_out", out_cnt - out_start, 6);
      chk("bp_queue_empty", q.size(), 0);

      // Counter: clear, 4 beats with 2 negatives, then 6 more to saturate the narrow one.
      i_cnt_clr = 1'b1;
      i_valid = 1'b0;
      cycle(acc);
      i_cnt_clr = 1'b0;
      chk("clr_cnt", o_zero_cnt, 16'd0);
      chk("clr_cnt4", o_zero_cnt4, 4'd0);
      for (int b = 0; b < 4; b++) begin
         send_model(pack16(-7, 5, -300, 9), 2'd1, 16'd0, 1'b0, 1'b0);
         cycle(acc);
      end
      drain();
      chk("cnt_8", o_zero_cnt, cnt_exp);
      chk("cnt4_8", o_zero_cnt4, cnt4_exp);
      for (int b = 0; b < 6; b++) begin
         send_model(pack16(-7, 5, -300, 9), 2'd1, 16'd0, 1'b0, 1'b0);
         cycle(acc);
      end
      drain();
      chk("cnt_20", o_zero_cnt, cnt_exp);
      chk("cnt4_sat", o_zero_cnt4, cnt4_exp);

      // Reset with two beats in flight.
      i_ready = 1'b0;
      send_model(pack16(-1, -2, 3, 4), 2'd1, 16'd0, 1'b1, 1'b0);
      cycle(acc);
      send_model(pack16(5, -6, 7, -8), 2'd1, 16'd0, 1'b1, 1'b0);
      cycle(acc);
      i_valid = 1'b0;
      reset = 1'b1;
      cycle(acc);
      reset = 1'b0;
      chk("mrst_o_valid", o_valid, 1'b0);
      chk("mrst_cnt", o_zero_cnt, 16'd0);
      chk("mrst_o_ready", o_ready, 1'b1);
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) cycle(acc);
      send_model(pack16(-9, 10, 200, -400), 2'd3, 16'd100, 1'b1, 1'b1);
      cycle(acc);
      drain();
      chk("mrst_cnt_after", o_zero_cnt, cnt_exp);

      // Clear in the same cycle as a transfer wins over the increment.
      send_model(pack16(-7, 5, -300, 9), 2'd1, 16'd0, 1'b0, 1'b0);
      cycle(acc);
      i_valid = 1'b0;
      cycle(acc);
      i_cnt_clr = 1'b1;
      cycle(acc);
      i_cnt_clr = 1'b0;
      chk("clr_xfer_done", q.size(), 0);
      chk("clr_xfer_cnt", o_zero_cnt, 16'd0);
      chk("clr_xfer_cnt4", o_zero_cnt4, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/relu_bound_pipe.md
Name: relu_bound_pipe

Overview:
- Parametrised, multi-lane activation stage between the bound/requantise stage and the activation buffer.
- Generalises the single-lane 8-bit combinational ReLU. Adds:
  - LANES parallel lanes
  - independent input and output widths with signed saturation
  - runtime mode select: bypass, ReLU, leaky ReLU, clipped ReLU
  - 2-stage valid/ready pipeline with backpressure
  - saturating zeroed-element statistics counter

Parameters:
- LANES, 4, number of parallel elements per beat.
- BO_BW, 16, signed width of each input element.
- ACT_BW, 8, signed width of each output element; must be <= BO_BW.
- LEAK_SHIFT, 3, arithmetic right-shift applied to negative inputs in leaky mode.
- CNT_BW, 16, width of the zeroed-element counter.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- i_valid, in, 1, input beat valid.
- o_ready, out, 1, block can accept an input beat.
- i_data, in, LANES*BO_BW, packed signed elements; lane 0 occupies bits [BO_BW-1:0].
- i_last, in, 1, end-of-tile marker; travels with the beat.
- i_mode, in, 2, 0 bypass, 1 ReLU, 2 leaky, 3 clipped; sampled with each accepted beat.
- i_clip, in, BO_BW, clip ceiling for mode 3; treated as unsigned and non-negative; sampled with each beat.
- o_valid, out, 1, output beat valid.
- i_ready, in, 1, downstream ready.
- o_data, out, LANES*ACT_BW, packed signed results; same lane order as i_data.
- o_last, out, 1, delayed i_last.
- i_cnt_clr, in, 1, synchronous clear of the counter.
- o_zero_cnt, out, CNT_BW, saturating count of lanes zeroed by a negative input.

Behaviour:
- Reset (synchronous, active-high): o_valid=0, o_data=0, o_last=0, o_zero_cnt=0, both stage-valid flags cleared. o_ready during reset is 1, derived combinationally from the cleared flags.
- Handshakes:
  - Input accepted when i_valid && o_ready.
  - Output transferred when o_valid && i_ready.
  - Stage 2 advances when !o_valid || i_ready.
  - Stage 1 advances when !s1_valid || stage-2 advance.
  - o_ready = !s1_valid || stage-2 advance. This is a combinational path from i_ready; no bubbles.
- Latency: an accepted beat appears on o_valid exactly 2 cycles later when unstalled. Throughput is 1 beat/cycle.
- o_data and o_last are held stable while o_valid && !i_ready.
- Stage 1, per lane, with x signed BO_BW, result kept at BO_BW width:
  - mode 0: y = x.
  - mode 1: y = x<0 ? 0 : x.
  - mode 2: y = x<0 ? (x >>> LEAK_SHIFT) : x. Arithmetic shift, so results floor toward negative infinity.
  - mode 3: y = x<0 ? 0 : min(x, i_clip).
  - Also per lane: neg flag = x<0 && mode in {1,3}.
- Stage 2, per lane: saturate y to the signed ACT_BW range [-2^(ACT_BW-1), 2^(ACT_BW-1)-1]. Register the result together with the lane count of neg flags.
- Counter:
  - On each output transfer, o_zero_cnt += popcount(neg flags). Saturates at 2^CNT_BW-1 and never wraps.
  - i_cnt_clr has priority over a simultaneous increment; the result that cycle is 0.
- Reset mid-stream: in-flight beats are discarded and no output transfer occurs after reset assertion. The first beat accepted after reset release appears 2 cycles later.
- Mode or clip changes mid-stream take effect per beat and never affect beats already accepted.

Decomposition:
- Shared package act_pkg holds:
  - mode encoding constants MODE_BYPASS=0, MODE_RELU=1, MODE_LEAKY=2, MODE_CLIP=3
  - a signed saturate function sat(x, from_bw, to_bw)
- One sub-module is natural: relu_lane. It is combinational and holds per-lane mode logic, neg flag and saturation.
- The top instantiates LANES relu_lanes via generate. The top owns pipeline registers, handshakes and the counter.

Test Plan (defaults LANES=4, BO_BW=16, ACT_BW=8, LEAK_SHIFT=3):
- ReLU, lanes {-5,0,100,300}, one beat -> o_valid 2 cycles later; o_data {0,0,100,127}; o_zero_cnt=1.
- Leaky, lanes {-80,-3,1000,-2000} -> {-10,-1,127,-128}; counter unchanged.
- Clipped, i_clip=6, lanes {-1,3,6,50} -> {0,3,6,6}; mode 0 on the same input -> {-1,3,6,50}.
- Backpressure: 6 back-to-back beats, i_ready low for 5 cycles from cycle 3 -> o_ready drops once 2 beats are held; o_data stable while stalled; all 6 beats emerge in order with no loss or duplicates; o_last marks beat 6 only.
- Counter: ReLU mode, 4 beats each with 2 negative lanes -> 8. With CNT_BW=4 and 10 such beats -> saturates at 15. i_cnt_clr asserted in the same cycle as a transfer -> 0.
- Reset asserted for 1 cycle with 2 beats in flight -> o_valid=0 and o_zero_cnt=0 the next cycle; neither beat ever appears; a new beat accepted afterwards emerges 2 cycles later.
